// File: rtl/bcd_sched_pkg.sv
// ============================================================================
// bcd_sched_pkg : shared types and constants for the BCD converter scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_sched_pkg;

   localparam int DEF_W_BIN = 12;
   localparam int DEF_W_BCD = 16;

   // Result word reported when a conversion is abandoned by the timeout.
   localparam logic [DEF_W_BCD-1:0] ERR_BCD = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-request round-robin picker
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      // Under contention the requester that did not win last time goes next.
      gnt_idx   = (req == 2'b11) ? ~last_grant : req[1];
   end

endmodule

`default_nettype wire

// File: rtl/bcd_conv_sched.sv
// ============================================================================
// bcd_conv_sched : round-robin sharing of one binary-to-BCD converter between
// two requesters. Optional macro BCD_SCHED_TIMEOUT_EN adds a WAIT timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_conv_sched
   import bcd_sched_pkg::*;
#(
   parameter int W_BIN       = DEF_W_BIN,
   parameter int W_BCD       = DEF_W_BCD,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   input  logic [W_BIN-1:0] req_bin0,
   input  logic [W_BIN-1:0] req_bin1,
   output logic [1:0]       req_ack,
   output logic [1:0]       res_valid,
   output logic [W_BCD-1:0] res_bcd,
   output logic             res_err,
   output logic             busy,
   output logic             conv_en,
   output logic [W_BIN-1:0] conv_bin,
   input  logic [W_BCD-1:0] conv_bcd,
   input  logic             conv_rdy
);

   state_e             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [1:0]         req_ack_q, req_ack_d;
   logic [1:0]         res_valid_q, res_valid_d;
   logic [W_BCD-1:0]   res_bcd_q, res_bcd_d;
   logic [W_BIN-1:0]   conv_bin_q, conv_bin_d;
   logic               res_err_d;
   logic               gnt_valid;
   logic               gnt_idx;

   rr_arb2 u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

`ifdef BCD_SCHED_TIMEOUT_EN
   localparam int              CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             res_err_q;
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      req_ack_d    = 2'b00;
      res_valid_d  = 2'b00;
      res_err_d    = 1'b0;
      res_bcd_d    = res_bcd_q;
      conv_bin_d   = conv_bin_q;
`ifdef BCD_SCHED_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               conv_bin_d   = gnt_idx ? req_bin1 : req_bin0;
               req_ack_d    = gnt_idx ? 2'b10 : 2'b01;
               last_grant_d = gnt_idx;
               state_d      = START;
            end
         end
         START: begin
`ifdef BCD_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = WAIT;
         end
         WAIT: begin
            // last_grant_q holds the owner of the job in flight.
            if (conv_rdy) begin
               res_bcd_d   = conv_bcd;
               res_valid_d = last_grant_q ? 2'b10 : 2'b01;
               state_d     = IDLE;
            end
`ifdef BCD_SCHED_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               res_bcd_d   = W_BCD'(ERR_BCD);
               res_valid_d = last_grant_q ? 2'b10 : 2'b01;
               res_err_d   = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         req_ack_q    <= 2'b00;
         res_valid_q  <= 2'b00;
         res_bcd_q    <= '0;
         conv_bin_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         req_ack_q    <= req_ack_d;
         res_valid_q  <= res_valid_d;
         res_bcd_q    <= res_bcd_d;
         conv_bin_q   <= conv_bin_d;
      end
   end

`ifdef BCD_SCHED_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         res_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         res_err_q <= res_err_d;
      end
   end

   assign res_err = res_err_q;
`else
   logic unused_res_err_d;
   assign unused_res_err_d = res_err_d;
   assign res_err          = 1'b0;
`endif

   assign req_ack   = req_ack_q;
   assign res_valid = res_valid_q;
   assign res_bcd   = res_bcd_q;
   assign conv_bin  = conv_bin_q;
   assign conv_en   = (state_q == START);
   assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
// ============================================================================
// tb_bcd_conv_sched : directed self-checking bench for bcd_conv_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_conv_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [11:0] req_bin0, req_bin1;
   logic [1:0]  req_ack, res_valid;
   logic [15:0] res_bcd;
   logic        res_err, busy, conv_en;
   logic [11:0] conv_bin;
   logic [15:0] conv_bcd;
   logic        conv_rdy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bcd_conv_sched #(.W_BIN(12), .W_BCD(16), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid),
      .req_bin0(req_bin0), .req_bin1(req_bin1),
      .req_ack(req_ack), .res_valid(res_valid), .res_bcd(res_bcd),
      .res_err(res_err), .busy(busy), .conv_en(conv_en),
      .conv_bin(conv_bin), .conv_bcd(conv_bcd), .conv_rdy(conv_rdy)
   );

   // Converter model: decimal digits of the operand packed as BCD.
   function automatic logic [15:0] bin2bcd(input logic [11:0] b);
      int v;
      v = int'(b);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 2'b00; conv_rdy = 1'b0; conv_bcd = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // One job from request to result; requests are driven and sampled at negedges.
   task automatic job(input logic [1:0] rv, input logic [1:0] exp_ack,
                      input logic [11:0] exp_bin, input logic [15:0] exp_bcd,
                      input int lat, input bit drop, output int waited);
      waited = 0;
      req_valid = rv;
      for (int i = 0; i < 10; i++) begin
         tick();
         waited++;
         if (req_ack != 2'b00) break;
      end
      n_checks++;
      if (req_ack !== exp_ack || conv_en !== 1'b1 || conv_bin !== exp_bin || res_valid !== 2'b00) begin
         $display("FAIL grant: ack=%b en=%b bin=%0d rv=%b required ack=%b en=1 bin=%0d rv=00",
                  req_ack, conv_en, conv_bin, res_valid, exp_ack, exp_bin);
      end else n_pass++;
      if (drop) req_valid = 2'b00;
      tick();
      n_checks++;
      if (req_ack !== 2'b00 || conv_en !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL wait_entry: ack=%b en=%b busy=%b required 00/0/1", req_ack, conv_en, busy);
      end else n_pass++;
      for (int i = 1; i < lat; i++) tick();
      conv_rdy = 1'b1;
      conv_bcd = bin2bcd(conv_bin);
      tick();
      conv_rdy = 1'b0;
      n_checks++;
      if (res_valid !== exp_ack || res_bcd !== exp_bcd || res_err !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL result: rv=%b bcd=%h err=%b busy=%b required rv=%b bcd=%h err=0 busy=0",
                  res_valid, res_bcd, res_err, busy, exp_ack, exp_bcd);
      end else n_pass++;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (req_ack !== 2'b00 || res_valid !== 2'b00 || res_err !== 1'b0 || res_bcd !== 16'h0000 ||
          conv_bin !== 12'd0 || conv_en !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL reset: ack=%b rv=%b err=%b bcd=%h bin=%0d en=%b busy=%b required all 0",
                  req_ack, res_valid, res_err, res_bcd, conv_bin, conv_en, busy);
      end else n_pass++;
   endtask

   task automatic test_single();
      int w;
      req_bin0 = 12'd255; req_bin1 = 12'd0;
      job(2'b01, 2'b01, 12'd255, 16'h0255, 8, 1'b1, w);
      tick();
      n_checks++;
      if (res_valid !== 2'b00 || res_bcd !== 16'h0255 || req_ack !== 2'b00) begin
         $display("FAIL single_hold: rv=%b bcd=%h ack=%b required 00/0255/00", res_valid, res_bcd, req_ack);
      end else n_pass++;
   endtask

   task automatic test_contention();
      int w;
      do_reset();
      req_bin0 = 12'd12; req_bin1 = 12'd7;
      job(2'b11, 2'b01, 12'd12, 16'h0012, 3, 1'b0, w);
      job(2'b11, 2'b10, 12'd7,  16'h0007, 2, 1'b0, w);
      job(2'b11, 2'b01, 12'd12, 16'h0012, 4, 1'b0, w);
      job(2'b11, 2'b10, 12'd7,  16'h0007, 1, 1'b1, w);
      tick();
   endtask

   task automatic test_stale_rdy();
      req_bin0 = 12'd999;
      conv_rdy = 1'b1; conv_bcd = 16'h1234;
      tick();
      conv_rdy = 1'b0;
      n_checks++;
      if (res_valid !== 2'b00 || busy !== 1'b0 || res_bcd !== 16'h0007) begin
         $display("FAIL stale_idle: rv=%b busy=%b bcd=%h required 00/0/0007", res_valid, busy, res_bcd);
      end else n_pass++;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      conv_rdy = 1'b1; conv_bcd = 16'h4321;
      tick();
      conv_rdy = 1'b0;
      n_checks++;
      if (res_valid !== 2'b00 || busy !== 1'b1 || conv_en !== 1'b0) begin
         $display("FAIL stale_start: rv=%b busy=%b en=%b required 00/1/0", res_valid, busy, conv_en);
      end else n_pass++;
      tick();
      conv_rdy = 1'b1; conv_bcd = bin2bcd(conv_bin);
      tick();
      conv_rdy = 1'b0;
      n_checks++;
      if (res_valid !== 2'b01 || res_bcd !== 16'h0999) begin
         $display("FAIL stale_done: rv=%b bcd=%h required 01/0999", res_valid, res_bcd);
      end else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      int w;
      req_bin1 = 12'd321;
      req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || res_valid !== 2'b00 || res_bcd !== 16'h0000 || conv_bin !== 12'd0) begin
         $display("FAIL reset_wait: busy=%b rv=%b bcd=%h bin=%0d required 0/00/0000/0",
                  busy, res_valid, res_bcd, conv_bin);
      end else n_pass++;
      conv_rdy = 1'b1; conv_bcd = 16'h0321;
      tick();
      conv_rdy = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || res_valid !== 2'b00 || res_bcd !== 16'h0000) begin
         $display("FAIL late_rdy: busy=%b rv=%b bcd=%h required 0/00/0000", busy, res_valid, res_bcd);
      end else n_pass++;
      // Tie after reset goes to requester 0.
      req_bin0 = 12'd40; req_bin1 = 12'd41;
      job(2'b11, 2'b01, 12'd40, 16'h0040, 2, 1'b1, w);
      tick();
   endtask

   task automatic test_back_to_back();
      int w;
      req_bin1 = 12'd1234;
      job(2'b10, 2'b10, 12'd1234, 16'h1234, 2, 1'b1, w);
      req_bin1 = 12'd4095;
      job(2'b10, 2'b10, 12'd4095, 16'h4095, 3, 1'b1, w);
      n_checks++;
      if (w !== 1) begin
         $display("FAIL back_to_back: grant after %0d cycles required 1", w);
      end else n_pass++;
      tick();
   endtask

`ifdef BCD_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      req_bin1 = 12'd77;
      req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      tick();
      n = 0;
      while (res_valid == 2'b00 && n < 40) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== 16 || res_valid !== 2'b10 || res_err !== 1'b1 || res_bcd !== 16'hFFFF) begin
         $display("FAIL timeout: cycles=%0d rv=%b err=%b bcd=%h required 16/10/1/ffff",
                  n, res_valid, res_err, res_bcd);
      end else n_pass++;
      tick();
      n_checks++;
      if (res_err !== 1'b0 || res_valid !== 2'b00 || busy !== 1'b0) begin
         $display("FAIL timeout_clear: err=%b rv=%b busy=%b required 0/00/0", res_err, res_valid, busy);
      end else n_pass++;
      req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      tick();
      for (int i = 0; i < 15; i++) tick();
      conv_rdy = 1'b1; conv_bcd = bin2bcd(conv_bin);
      tick();
      conv_rdy = 1'b0;
      n_checks++;
      if (res_err !== 1'b0 || res_valid !== 2'b10 || res_bcd !== 16'h0077) begin
         $display("FAIL rdy_vs_timeout: err=%b rv=%b bcd=%h required 0/10/0077", res_err, res_valid, res_bcd);
      end else n_pass++;
      tick();
   endtask
`endif

   initial begin
      rst = 1'b1; req_valid = 2'b00; req_bin0 = '0; req_bin1 = '0;
      conv_rdy = 1'b0; conv_bcd = '0;
      test_reset();
      test_single();
      test_contention();
      test_stale_rdy();
      test_reset_in_wait();
      test_back_to_back();
`ifdef BCD_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Two-requester scheduler that shares the single binary-to-BCD converter (12-bit binary in, 16-bit BCD out, one-cycle `en` start, one-cycle `rdy` done).
- Requester 0 is the ALU result path; requester 1 is a secondary display source (operand echo).
- Arbitrates round-robin, captures the granted operand, sequences the converter, and returns the BCD word with a per-requester completion pulse.
- Sits between the ALU/operand logic and the seven-segment driver's BCD register.

Parameters:
- W_BIN, 12, width of the binary operand.
- W_BCD, 16, width of the BCD result (4 digits).
- TIMEOUT_CYC, 64, cycles allowed in WAIT before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request; bit i belongs to requester i.
- req_bin0  in  W_BIN  operand of requester 0.
- req_bin1  in  W_BIN  operand of requester 1.
- req_ack  out  2  one-cycle accept pulse, registered.
- res_valid  out  2  one-cycle result pulse for the owning requester, registered.
- res_bcd  out  W_BCD  last converted result, held until the next completion.
- res_err  out  1  one-cycle timeout pulse, coincident with res_valid.
- busy  out  1  high whenever state != IDLE.
- conv_en  out  1  converter start; high exactly one cycle per job.
- conv_bin  out  W_BIN  converter operand, registered and stable from START through WAIT.
- conv_bcd  in  W_BCD  converter result.
- conv_rdy  in  1  converter done pulse.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, req_ack=0, res_valid=0, res_err=0, res_bcd=0, conv_bin=0, conv_en=0, busy=0, last_grant=1 (requester 0 wins the first tie).
- States: IDLE -> START -> WAIT -> IDLE.
- IDLE, arbitration:
  - req_valid is sampled only in IDLE.
  - Exactly one bit set: grant that requester.
  - Both bits set: grant !last_grant.
  - At the grant edge: conv_bin<=selected operand, req_ack[g]<=1, last_grant<=g, state<=START.
- START:
  - conv_en=1, decoded from state==START, for one cycle only.
  - req_ack is high during this cycle.
  - Next edge: req_ack<=0, state<=WAIT.
- WAIT:
  - conv_en=0.
  - On an edge with conv_rdy=1: res_bcd<=conv_bcd, res_valid[g]<=1, state<=IDLE.
  - A new grant may occur in the following IDLE cycle.
- Latency: valid sampled at edge N -> ack visible in cycle N+1 -> conv_en in cycle N+1 -> result pulse one cycle after the rdy edge.
- Requester rule: drop req_valid in the cycle after ack is seen. Still high on the next IDLE sample = a new request.
- conv_rdy outside WAIT (stale, or seen during START) is ignored.
- res_valid and res_err are single-cycle pulses, cleared on the next edge.
- Reset mid-operation: everything returns to reset values on that edge. A later conv_rdy from the abandoned job is ignored in IDLE. res_bcd clears to 0.
- Simultaneous events: new req_valid while in START or WAIT is held off, with no ack until IDLE. Fairness alternates strictly under continuous contention.

Optional Feature:
- Macro: BCD_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 with no conv_rdy: res_bcd<=all 1s (16'hFFFF), res_valid[g]<=1, res_err<=1, state<=IDLE.
  - If conv_rdy arrives on the same edge as the timeout, conv_rdy wins (normal completion, no error).
- Undefined:
  - No counter; WAIT persists until conv_rdy.
  - res_err is tied 0. The port remains.

Decomposition:
- Package bcd_sched_pkg:
  - state encoding (IDLE=2'd0, START=2'd1, WAIT=2'd2)
  - W_BIN/W_BCD defaults
  - all-ones error code constant.
- One sub-module, rr_arb2: two-request round-robin picker. Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_idx. Combinational, instantiated once.

Test Plan:
- Single request: req_valid=01, req_bin0=12'd255, converter model returns 16'h0255 after 8 cycles -> req_ack=01 for one cycle, conv_en one pulse with conv_bin=255, res_valid=01, res_bcd=16'h0255.
- Contention: req_valid=11 from reset, bin0=12, bin1=7, both held across acks -> grant order 0,1,0,1; res_bcd 0x0012, 0x0007, 0x0012, 0x0007.
- Stale rdy: conv_rdy pulsed while in IDLE and during START -> no res_valid, state unchanged/advances normally.
- Reset in WAIT: rst at cycle 3 of WAIT, converter rdy arrives later -> busy=0, res_valid stays 0, res_bcd=0.
- Back-to-back: requester 1 re-asserts immediately after its res_valid -> granted in the first IDLE cycle, conv_en exactly one cycle each job.
- Timeout (macro defined, TIMEOUT_CYC=16): converter never responds -> after 16 WAIT cycles res_valid=10, res_err=1, res_bcd=16'hFFFF. Rdy and timeout on the same edge -> res_err=0.
